// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl
//   Time-shares one edge counter across N_RINGS ring oscillators. Each
//   scheduled ring is enabled for a settle interval, then the rising edges
//   of its divided output are counted over a fixed gate window in the clk
//   domain. The result is reported and the scan moves on to the next ring
//   in the latched mask.
//
// Ports
//   clk           system clock
//   rst_n         synchronous active-low reset
//   start         begin a scan (only honoured in IDLE)
//   stop          abort / leave continuous mode (any non-IDLE state)
//   continuous    wrap to the first masked ring after the last (latched at start)
//   ring_mask     rings to measure (latched at start)
//   osc_div_in    divided ring outputs, asynchronous to clk
//   ring_enable   -> ring_ena: one-hot enable of the ring being settled/measured
//   busy          high whenever not IDLE
//   result_valid  one-cycle pulse while a new result is presented
//   result_ring   index of the ring last measured
//   result_count  edges counted in the gate (saturating)
//   done          one-cycle pulse after a non-continuous scan completes
module ring_osc_meas_ctrl #(
  parameter int unsigned N_RINGS       = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [N_RINGS-1:0] ring_mask,
  input  logic [N_RINGS-1:0] osc_div_in,
  output logic [N_RINGS-1:0] ring_ena,
  output logic               busy,
  output logic               result_valid,
  output logic [2:0]         result_ring,
  output logic [COUNT_W-1:0] result_count,
  output logic               done
);

  localparam int unsigned TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [COUNT_W-1:0] count, count_nxt;
  logic [N_RINGS-1:0] mask_q, mask_nxt;
  logic               cont_q, cont_nxt;
  logic [2:0]         res_ring_nxt;
  logic [COUNT_W-1:0] res_count_nxt;
  logic               done_nxt;

  logic [N_RINGS-1:0] sync1, sync2, sync3;
  logic [N_RINGS-1:0] edge_vec;
  logic               sel_edge;
  logic [2:0]         low_in, low_q, next_idx;
  logic               has_next;

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= osc_div_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_vec = sync2 & ~sync3;

  always_comb begin
    sel_edge = 1'b0;
    for (int unsigned i = 0; i < N_RINGS; i++) begin
      if (idx == 3'(i)) sel_edge = edge_vec[i];
    end
  end

  // Lowest set bit of the live mask (for start) and of the latched mask
  // (for wrap); scanning downward leaves the lowest match last.
  always_comb begin
    low_in = '0;
    low_q  = '0;
    for (int unsigned i = N_RINGS; i > 0; i--) begin
      if (ring_mask[i-1]) low_in = 3'(i - 1);
      if (mask_q[i-1])    low_q  = 3'(i - 1);
    end
  end

  // Nearest latched mask bit strictly above the current ring.
  always_comb begin
    has_next = 1'b0;
    next_idx = '0;
    for (int unsigned i = N_RINGS; i > 0; i--) begin
      if (mask_q[i-1] && (3'(i - 1) > idx)) begin
        has_next = 1'b1;
        next_idx = 3'(i - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      timer        <= '0;
      count        <= '0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      result_ring  <= '0;
      result_count <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      timer        <= timer_nxt;
      count        <= count_nxt;
      mask_q       <= mask_nxt;
      cont_q       <= cont_nxt;
      result_ring  <= res_ring_nxt;
      result_count <= res_count_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    timer_nxt     = timer;
    count_nxt     = count;
    mask_nxt      = mask_q;
    cont_nxt      = cont_q;
    res_ring_nxt  = result_ring;
    res_count_nxt = result_count;
    done_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !stop && (ring_mask != '0)) begin
          mask_nxt  = ring_mask;
          cont_nxt  = continuous;
          idx_nxt   = low_in;
          timer_nxt = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (timer == TW'(SETTLE_CYCLES - 1)) begin
          timer_nxt = '0;
          count_nxt = '0;
          state_nxt = S_MEASURE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_MEASURE: begin
        if (sel_edge && (count != '1)) count_nxt = count + 1'b1;
        // The final gate cycle's edge is folded into the captured result.
        if (timer == TW'(GATE_CYCLES - 1)) begin
          timer_nxt     = '0;
          res_ring_nxt  = idx;
          res_count_nxt = count_nxt;
          state_nxt     = S_REPORT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_REPORT: begin
        if (has_next) begin
          idx_nxt   = next_idx;
          state_nxt = S_SETTLE;
        end else if (cont_q) begin
          idx_nxt   = low_q;
          state_nxt = S_SETTLE;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort overrides every transition above and discards any capture.
    if (stop && (state != S_IDLE)) begin
      state_nxt     = S_IDLE;
      timer_nxt     = '0;
      done_nxt      = 1'b0;
      res_ring_nxt  = result_ring;
      res_count_nxt = result_count;
    end
  end

  always_comb begin
    ring_ena = '0;
    if ((state == S_SETTLE) || (state == S_MEASURE)) begin
      for (int unsigned i = 0; i < N_RINGS; i++) begin
        if (idx == 3'(i)) ring_ena[i] = 1'b1;
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Self-checking bench for ring_osc_meas_ctrl. Oscillator inputs are square
// waves of randomised half-period; expected counts come from the recorded
// per-edge input history, counting rising transitions inside each ring's
// gate window shifted by the synchronizer delay.
module tb_ring_osc_meas_ctrl;

  localparam int S    = 8;
  localparam int G    = 100;
  localparam int CW   = 5;
  localparam int P    = S + G + 1;
  localparam int MAXC = 31;
  localparam int HN   = 20000;

  typedef struct {
    int e;
    int ring;
    int cnt;
  } res_t;

  logic          clk, rst_n, start, stop, continuous;
  logic [3:0]    ring_mask, osc_div_in, ring_ena;
  logic          busy, result_valid, done;
  logic [2:0]    result_ring;
  logic [CW-1:0] result_count;

  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;
  bit   hist [4][HN];
  int   hp [4] = '{default: 0};
  int   gcnt [4] = '{default: 0};
  bit   mon_en = 1'b0;
  int   ena_cyc [4] = '{default: 0};
  res_t res_q [$];
  int   done_q [$];

  ring_osc_meas_ctrl #(
    .N_RINGS      (4),
    .SETTLE_CYCLES(S),
    .GATE_CYCLES  (G),
    .COUNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .ring_mask   (ring_mask),
    .osc_div_in  (osc_div_in),
    .ring_ena    (ring_ena),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ring (result_ring),
    .result_count(result_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Record what each edge samples; edge index = ecount before increment.
  always @(posedge clk) begin
    if (ecount < HN) begin
      for (int r = 0; r < 4; r++) hist[r][ecount] = osc_div_in[r];
    end
    ecount++;
  end

  // Square-wave oscillator inputs, toggling every hp[r] clocks.
  initial begin
    osc_div_in = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
        if (hp[r] > 0) begin
          gcnt[r]++;
          if (gcnt[r] >= hp[r]) begin
            gcnt[r] = 0;
            osc_div_in[r] = ~osc_div_in[r];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ena_onehot", 32'($countones(ring_ena) <= 1), 32'd1);
      for (int r = 0; r < 4; r++) if (ring_ena[r]) ena_cyc[r]++;
      if (result_valid) res_q.push_back('{ecount - 1, int'(result_ring), int'(result_count)});
      if (done) done_q.push_back(ecount - 1);
    end
  end

  // Rising transitions of ring r seen during the gate of a ring whose
  // settle began at edge tk; the synchronizer delays detection by two edges.
  function automatic int exp_count(int r, int tk);
    int c = 0;
    for (int j = tk + S; j < tk + S + G; j++)
      if (hist[r][j-1] && !hist[r][j-2]) c++;
    return (c > MAXC) ? MAXC : c;
  endfunction

  task automatic run_scan(input logic [3:0] m, input string tag);
    int t0, base_r, base_d, n;
    int ena0 [4];
    int order [$];
    base_r = res_q.size();
    base_d = done_q.size();
    for (int r = 0; r < 4; r++) ena0[r] = ena_cyc[r];
    for (int r = 0; r < 4; r++) if (m[r]) order.push_back(r);
    n = order.size();
    ring_mask  = m;
    continuous = 1'b0;
    start      = 1'b1;
    t0         = ecount;
    tick();
    start      = 1'b0;
    // Changes while busy must not matter.
    ring_mask  = 4'($urandom);
    continuous = 1'($urandom);
    for (int i = 0; (i < n * P + 10) && (done_q.size() == base_d); i++) tick();
    chk({tag, "_done_n"}, 32'(done_q.size() - base_d), 32'd1);
    chk({tag, "_res_n"}, 32'(res_q.size() - base_r), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base_r + k < res_q.size()) begin
        chk({tag, "_ring"}, 32'(res_q[base_r+k].ring), 32'(order[k]));
        chk({tag, "_count"}, 32'(res_q[base_r+k].cnt), 32'(exp_count(order[k], t0 + k * P)));
        chk({tag, "_rv_time"}, 32'(res_q[base_r+k].e), 32'(t0 + k * P + S + G));
      end
    end
    if (done_q.size() > base_d) chk({tag, "_done_time"}, 32'(done_q[base_d]), 32'(t0 + n * P));
    for (int r = 0; r < 4; r++)
      chk({tag, "_ena_cycles"}, 32'(ena_cyc[r] - ena0[r]), 32'(m[r] ? S + G : 0));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, base_r, base_d;
    logic [3:0] m;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; ring_mask = '0;
    repeat (3) tick();
    chk("rst_ring_ena", 32'(ring_ena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ring", 32'(result_ring), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    hp = '{5, 0, 0, 0};
    repeat (20) tick();
    run_scan(4'b0001, "single");

    // Unselected rings 0 and 2 toggle fast throughout.
    hp = '{1, 5, 2, 10};
    repeat (5) tick();
    run_scan(4'b1010, "pair");

    hp = '{3, 0, 1, 0};
    repeat (5) tick();
    run_scan(4'b0100, "sat");
    chk("sat_value", 32'(result_count), 32'd31);

    // Continuous scan, stopped in the gate of the third measurement.
    hp = '{4, 3, 0, 0};
    base_r = res_q.size();
    base_d = done_q.size();
    ring_mask = 4'b0011; continuous = 1'b1; start = 1'b1;
    t0 = ecount;
    tick();
    start = 1'b0; ring_mask = 4'b1000; continuous = 1'b0;
    while (ecount < t0 + 2 * P + S + 50) tick();
    chk("cont_ena_third", 32'(ring_ena), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_ena", 32'(ring_ena), 32'd0);
    repeat (2 * P) tick();
    chk("cont_res_n", 32'(res_q.size() - base_r), 32'd2);
    chk("cont_done_n", 32'(done_q.size() - base_d), 32'd0);
    for (int k = 0; k < 2; k++) begin
      if (base_r + k < res_q.size()) begin
        chk("cont_ring", 32'(res_q[base_r+k].ring), 32'(k));
        chk("cont_count", 32'(res_q[base_r+k].cnt), 32'(exp_count(k, t0 + k * P)));
      end
    end

    // Stop during the REPORT cycle: that result still appears, nothing after.
    hp = '{0, 6, 2, 0};
    base_r = res_q.size();
    base_d = done_q.size();
    ring_mask = 4'b0110; continuous = 1'b0; start = 1'b1;
    t0 = ecount;
    tick();
    start = 1'b0;
    while (ecount < t0 + S + G + 1) tick();
    chk("rep_valid", 32'(result_valid), 32'd1);
    chk("rep_ring", 32'(result_ring), 32'd1);
    chk("rep_count", 32'(result_count), 32'(exp_count(1, t0)));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("rep_stop_busy", 32'(busy), 32'd0);
    repeat (P) tick();
    chk("rep_res_n", 32'(res_q.size() - base_r), 32'd1);
    chk("rep_done_n", 32'(done_q.size() - base_d), 32'd0);

    // Empty mask start is ignored.
    base_r = res_q.size();
    base_d = done_q.size();
    ring_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mask0_busy", 32'(busy), 32'd0);
    chk("mask0_ena", 32'(ring_ena), 32'd0);

    // Simultaneous start and stop in IDLE: stop wins.
    ring_mask = 4'b0001; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("idle_res_n", 32'(res_q.size() - base_r), 32'd0);
    chk("idle_done_n", 32'(done_q.size() - base_d), 32'd0);

    for (int it = 0; it < 5; it++) begin
      for (int r = 0; r < 4; r++) hp[r] = $urandom_range(0, 7);
      m = 4'($urandom_range(1, 15));
      repeat (3) tick();
      run_scan(m, "rand");
    end

    // Reset in the middle of SETTLE.
    base_r = res_q.size();
    base_d = done_q.size();
    ring_mask = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ena", 32'(ring_ena), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ring", 32'(result_ring), 32'd0);
    chk("midrst_count", 32'(result_count), 32'd0);
    repeat (P + 5) tick();
    chk("midrst_res_n", 32'(res_q.size() - base_r), 32'd0);
    chk("midrst_done_n", 32'(done_q.size() - base_d), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_osc_meas_ctrl.md
Name: ring_osc_meas_ctrl

Overview:
- Scheduler that shares one frequency-measurement counter among N_RINGS free-running ring oscillators.
- Enables one ring at a time, waits a settle interval, then counts rising edges of that ring's divided output over a fixed gate window in the clk domain.
- Reports each result, then advances to the next ring selected by the mask.
- Sits between the ring_osc instances and their divider counters on one side, and the uo/uio pin logic on the other.

Parameters:
- N_RINGS, 4, number of rings / osc_div_in lines (2..8)
- SETTLE_CYCLES, 16, clk cycles a ring is enabled before the gate opens (>=1)
- GATE_CYCLES, 1024, clk cycles in the measurement gate (>=2)
- COUNT_W, 16, width of the edge counter and result_count

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- stop  in  1  abort or leave continuous mode; sampled in every state
- continuous  in  1  1 = after the last masked ring, wrap to the first; latched at start
- ring_mask  in  N_RINGS  rings to measure; latched at start
- osc_div_in  in  N_RINGS  divided ring outputs; asynchronous to clk
- ring_ena  out  N_RINGS  one-hot enable to the selected ring_osc, else 0
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  one-cycle pulse when a new result is presented
- result_ring  out  3  index of the ring measured
- result_count  out  COUNT_W  rising edges counted during the gate
- done  out  1  one-cycle pulse when a non-continuous scan completes

Behaviour:
- Reset is synchronous and active-low: rst_n low at a clk rising edge forces:
  - state=IDLE
  - ring_ena=0, busy=0, result_valid=0, done=0
  - result_ring=0, result_count=0
  - all synchronizer flops and internal counters=0
- Reset mid-operation aborts immediately; no result and no done.
- Input synchronization: each osc_div_in bit passes through its own 2-flop synchronizer plus a third flop. edge[i] = s2[i] & ~s3[i]. Only edge[idx] of the selected ring is counted.
- IDLE:
  - start=1 and ring_mask!=0 → latch the mask and continuous; idx = lowest set bit; go to SETTLE.
  - start=1 with ring_mask==0 is ignored (stays in IDLE, no pulses).
- SETTLE:
  - ring_ena = one-hot(idx).
  - Lasts exactly SETTLE_CYCLES cycles, then go to MEASURE with the edge counter cleared.
- MEASURE:
  - ring_ena is still one-hot(idx).
  - Lasts exactly GATE_CYCLES cycles.
  - Each cycle with edge[idx]=1, count increments. It saturates at 2^COUNT_W-1 and never wraps.
  - An edge in the final gate cycle is counted. Edges outside MEASURE are never counted.
- REPORT (1 cycle):
  - ring_ena=0, result_valid=1.
  - result_ring and result_count are updated and held until the next REPORT.
  - Next state:
    - higher set bit in the latched mask → idx = next set bit, go to SETTLE;
    - else continuous=1 → idx = lowest set bit, go to SETTLE;
    - else go to IDLE with done=1 in that IDLE cycle.
- Latency: with start sampled at edge T:
  - ring_ena rises at T+1.
  - MEASURE spans cycles T+1+SETTLE_CYCLES .. T+SETTLE_CYCLES+GATE_CYCLES.
  - result_valid is high in cycle T+1+SETTLE_CYCLES+GATE_CYCLES.
  - Per-ring period = SETTLE_CYCLES+GATE_CYCLES+1.
- stop:
  - stop=1 in any non-IDLE state → IDLE next cycle with ring_ena=0.
  - The partial count is discarded; no result_valid, no done.
  - stop has priority over REPORT transitions. If stop is asserted in the REPORT cycle, that cycle's result_valid still occurs.
- Simultaneous start and stop in IDLE: stop wins; stay in IDLE.
- Changes to ring_mask or continuous while busy have no effect until the next start.
- At most one ring_ena bit is ever high.

Test Plan:
- Params SETTLE=8, GATE=100. mask=4'b0001; osc_div_in[0] toggles every 5 clk → result_valid at start+109, result_ring=0, result_count=10 (±1); done one cycle later; ring_ena[0] high for exactly 108 cycles.
- mask=4'b1010, continuous=0; ring1 period 10, ring3 period 20 → results (1,10±1) then (3,5±1), 109 cycles apart; ring_ena never shows two bits set; a single done.
- COUNT_W=5, osc_div_in[2] toggles every clk (50 edges in gate), mask=4'b0100 → result_count=31 (saturated).
- continuous=1, mask=4'b0011 → result_ring sequence 0,1,0,1…; assert stop mid-MEASURE of the 3rd ring → next cycle busy=0, ring_ena=0, no further result_valid, no done.
- start with mask=0 → stays IDLE, busy=0, no pulses. rst_n=0 mid-SETTLE → next cycle all outputs at reset values.
- Edges on an unselected ring's osc_div_in during a measurement → result_count unaffected.
